// File: rtl/tdm_demux4x1.sv
// Receive side of a 4-slot TDM link: hunts for the slot-0 frame marker, locks,
// and publishes all four recovered channels together once per complete frame.
module tdm_demux4x1 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t            state;
  logic [1:0]        slot;
  logic [DATA_W-1:0] s0, s1, s2;
  logic              run;
  logic              beat;

  // Reset release is retimed so no beat is taken on the edge where rst_n
  // first reads high; the first beat lands on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign beat   = din_valid && run;
  assign locked = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow registers are reset along with q0..q3 so that a reset
    // mid-frame can never leak stale slot data into a later frame.
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      q0          <= '0;
      q1          <= '0;
      q2          <= '0;
      q3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below are
      // overridden later in the same block, so last assignment wins per edge.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (beat) begin
        if (state == HUNT) begin
          if (sync) begin
            s0    <= din;
            slot  <= 2'd1;
            state <= LOCK;
          end
        end else if (sync && slot != 2'd0) begin
          // Early marker: drop the partial frame and restart on this beat.
          sync_err <= 1'b1;
          s0       <= din;
          slot     <= 2'd1;
        end else if (!sync && slot == 2'd0) begin
          sync_err <= 1'b1;
          slot     <= 2'd0;
          state    <= HUNT;
        end else begin
          case (slot)
            2'd0: s0 <= din;
            2'd1: s1 <= din;
            2'd2: s2 <= din;
            default: begin
              q0          <= s0;
              q1          <= s1;
              q2          <= s2;
              q3          <= din;
              frame_valid <= 1'b1;
            end
          endcase
          slot <= slot + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4x1.sv
// Directed bench for tdm_demux4x1: stimulus pushes expected frame/error events,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_tdm_demux4x1;

  localparam int DATA_W = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              sync = 1'b0;
  logic [DATA_W-1:0] q0, q1, q2, q3;
  logic              frame_valid, locked, sync_err;

  typedef struct {
    logic       is_err;
    logic [3:0] q;     // {q0,q1,q2,q3} expected while the pulse is high
  } event_t;

  event_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  tdm_demux4x1 #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] qv();
    return {q0[0], q1[0], q2[0], q3[0]};
  endfunction

  task automatic beat(input logic s, input logic d);
    din_valid = 1'b1;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic is_err, input logic [3:0] q);
    event_t e;
    e.is_err = is_err;
    e.q      = q;
    exp_q.push_back(e);
  endtask

  // Monitor: every frame_valid / sync_err pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || sync_err)) begin
      event_t e;
      if (frame_valid && sync_err) begin
        check("pulses_exclusive", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, sync_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_err", {31'd0, sync_err}, {31'd0, e.is_err});
        check("event_q", {28'd0, qv()}, {28'd0, e.q});
      end
    end
  end

  initial begin
    // Reset state
    idle(2);
    check("reset_q", {28'd0, qv()}, 32'd0);
    check("reset_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);

    // Release mid-cycle; a sync beat on the very next edge must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 1'b1);
    check("first_edge_ignored", {31'd0, locked}, 32'd0);

    // Hunt filtering: beats without sync are discarded silently.
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'(i));
      check("hunt_locked", {31'd0, locked}, 32'd0);
    end
    check("hunt_q", {28'd0, qv()}, 32'd0);

    // Clean frame 1,0,1,1
    push(1'b0, 4'b1011);
    beat(1'b1, 1'b1);
    check("lock_rise", {31'd0, locked}, 32'd1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    check("no_partial_update", {28'd0, qv()}, 32'd0);
    beat(1'b0, 1'b1);
    check("clean_q", {28'd0, qv()}, 32'h0000000b);
    idle(2);

    // Gapped frame 0,1,0,0 with three idle cycles between beats
    push(1'b0, 4'b0100);
    beat(1'b1, 1'b0);
    idle(3);
    beat(1'b0, 1'b1);
    idle(3);
    beat(1'b0, 1'b0);
    idle(3);
    check("gap_q_hold", {28'd0, qv()}, 32'h0000000b);
    beat(1'b0, 1'b0);
    check("gap_q", {28'd0, qv()}, 32'h00000004);
    idle(2);

    // Early sync: partial 1,1 dropped, new frame 0,1,1,0
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    push(1'b1, 4'b0100);
    beat(1'b1, 1'b0);
    check("early_locked", {31'd0, locked}, 32'd1);
    push(1'b0, 4'b0110);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    idle(2);

    // Good frame 1,0,1,1 then a missing sync on slot 0
    push(1'b0, 4'b1011);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    push(1'b1, 4'b1011);
    beat(1'b0, 1'b1);
    check("missing_unlock", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
    check("missing_q_hold", {28'd0, qv()}, 32'h0000000b);
    check("missing_stay_hunt", {31'd0, locked}, 32'd0);

    // Relock with frame 0,0,1,0
    push(1'b0, 4'b0010);
    beat(1'b1, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    idle(2);

    // Async reset mid-frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_q", {28'd0, qv()}, 32'd0);
    check("async_locked", {31'd0, locked}, 32'd0);
    #2 rst_n = 1'b1;
    idle(1);
    push(1'b0, 4'b1101);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    check("post_reset_q", {28'd0, qv()}, 32'h0000000d);
    idle(3);

    check("events_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
